// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared types and constants for the instruction fetch stage
package instruction_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_e;

  localparam logic [5:0]  OP_LD_WORD       = 6'b000000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Branch targets are byte addresses; instructions are word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - RAM access bus between the fetch stage and ram512x8
interface instruction_fetch_if #(
  parameter int ADDR_WIDTH = 9
);
  logic                  RAM_enable;
  logic [5:0]            RAM_OpCode;
  logic [ADDR_WIDTH-1:0] RAM_Addr;
  logic                  MFC;
  logic [31:0]           RAM_Out;

  modport master (
    output RAM_enable,
    output RAM_OpCode,
    output RAM_Addr,
    input  MFC,
    input  RAM_Out
  );

  modport slave (
    input  RAM_enable,
    input  RAM_OpCode,
    input  RAM_Addr,
    output MFC,
    output RAM_Out
  );
endinterface

// File: rtl/instruction_fetch_mfc_watchdog.sv
// rtl/instruction_fetch_mfc_watchdog.sv - MFC timeout counter, built only with FETCH_TIMEOUT_EN
`ifdef FETCH_TIMEOUT_EN
module instruction_fetch_mfc_watchdog #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic in_wait_i,
  input  logic mfc_i,
  output logic expire_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive WAIT cycles that end without MFC; any other cycle restarts.
  always_comb begin
    cnt_d = '0;
    if (in_wait_i && !mfc_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register with synchronous active-low clear.
  always_ff @(posedge clk_i) begin
    if (!clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The last allowed WAIT cycle is the one where the count already holds TIMEOUT-1.
  assign expire_o = in_wait_i && !mfc_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
endmodule
`endif

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - SPARC PC/NPC fetch stage with delayed-branch redirect (optional FETCH_TIMEOUT_EN)
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter int          ADDR_WIDTH     = 9,
  parameter int          TIMEOUT_CYCLES = 15
) (
  input  logic                Clk,
  input  logic                Clr,
  input  logic                fetch_req,
  input  logic                redirect,
  input  logic [31:0]         redirect_target,
  instruction_fetch_if.master ram,
  output logic [31:0]         IR_In,
  output logic                IR_Enable,
  output logic                ir_valid,
  output logic                busy,
  output logic [31:0]         pc_out,
  output logic [31:0]         npc_out,
  output logic                fetch_fault
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  npc_q, npc_d;
  logic [31:0]  ir_q, ir_d;
  logic         pend_q, pend_d;
  logic [31:0]  pend_tgt_q, pend_tgt_d;
  logic         timeout_hit;

`ifdef FETCH_TIMEOUT_EN
  instruction_fetch_mfc_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (Clk),
    .clr_i    (Clr),
    .in_wait_i(state_q == ST_WAIT),
    .mfc_i    (ram.MFC),
    .expire_o (timeout_hit)
  );
  assign fetch_fault = (state_q == ST_FAULT);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign fetch_fault        = 1'b0;
`endif

  // State register.
  always_ff @(posedge Clk) begin
    if (!Clr) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: MFC is only honoured in WAIT, fetch_req only in IDLE and DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (fetch_req) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (ram.MFC) begin
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          state_d = ST_FAULT;
        end
      end
      ST_DONE:  state_d = fetch_req ? ST_ISSUE : ST_IDLE;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // PC/NPC, IR and pending-redirect updates; a live redirect in DONE beats a pending one.
  always_comb begin
    pc_d       = pc_q;
    npc_d      = npc_q;
    ir_d       = ir_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    case (state_q)
      ST_WAIT: if (ram.MFC) ir_d = ram.RAM_Out;
      ST_DONE: begin
        pc_d   = npc_q;
        pend_d = 1'b0;
        if (redirect) begin
          npc_d = word_align(redirect_target);
        end else if (pend_q) begin
          npc_d = pend_tgt_q;
        end else begin
          npc_d = npc_q + 32'd4;
        end
      end
      default: ;
    endcase
    if (redirect && (state_q != ST_DONE)) begin
      pend_d     = 1'b1;
      pend_tgt_d = word_align(redirect_target);
    end
  end

  // Datapath registers.
  always_ff @(posedge Clk) begin
    if (!Clr) begin
      pc_q       <= RESET_PC;
      npc_q      <= RESET_PC + 32'd4;
      ir_q       <= 32'h0;
      pend_q     <= 1'b0;
      pend_tgt_q <= 32'h0;
    end else begin
      pc_q       <= pc_d;
      npc_q      <= npc_d;
      ir_q       <= ir_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  // Strobes decoded purely from the current state.
  always_comb begin
    ram.RAM_enable = 1'b0;
    IR_Enable      = 1'b0;
    ir_valid       = 1'b0;
    busy           = (state_q != ST_IDLE);
    case (state_q)
      ST_ISSUE, ST_WAIT: ram.RAM_enable = 1'b1;
      ST_DONE: begin
        IR_Enable = 1'b1;
        ir_valid  = 1'b1;
      end
      default: ;
    endcase
  end

  assign ram.RAM_OpCode = OP_LD_WORD;
  assign ram.RAM_Addr   = pc_q[ADDR_WIDTH-1:0];
  assign IR_In          = ir_q;
  assign pc_out         = pc_q;
  assign npc_out        = npc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch (FETCH_TIMEOUT_EN aware)
module tb_instruction_fetch;

  logic        clk;
  logic        clr;
  logic        fetch_req;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] ir_in;
  logic        ir_enable;
  logic        ir_valid;
  logic        busy;
  logic [31:0] pc_out;
  logic [31:0] npc_out;
  logic        fetch_fault;

  instruction_fetch_if #(.ADDR_WIDTH(9)) bus ();

  instruction_fetch #(
    .RESET_PC      (32'h0000_0000),
    .ADDR_WIDTH    (9),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .Clk            (clk),
    .Clr            (clr),
    .fetch_req      (fetch_req),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .ram            (bus),
    .IR_In          (ir_in),
    .IR_Enable      (ir_enable),
    .ir_valid       (ir_valid),
    .busy           (busy),
    .pc_out         (pc_out),
    .npc_out        (npc_out),
    .fetch_fault    (fetch_fault)
  );

  int          total;
  int          bad;
  logic [31:0] mem [0:127];
  logic [8:0]  addr_log [$];
  int          rcnt;
  int          mfc_delay;
  bit          mfc_on;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock; sample #1 after the edge, then update the RAM responder model.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.RAM_enable) begin
      rcnt++;
      if (rcnt == 1) addr_log.push_back(bus.RAM_Addr);
    end else begin
      rcnt = 0;
    end
    bus.MFC     = mfc_on && bus.RAM_enable && (rcnt >= mfc_delay + 2);
    bus.RAM_Out = mem[bus.RAM_Addr[8:2]];
  endtask

  task automatic do_reset();
    clr = 1'b0;
    tick();
    clr = 1'b1;
    addr_log.delete();
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (ir_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    fetch_req = 1'b1;
    do_reset();
    fetch_req = 1'b0;
    total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=%h", pc_out, 32'h0); end
    total++; if (npc_out !== 32'h4) begin bad++; $display("FAIL reset_npc got=%h want=%h", npc_out, 32'h4); end
    total++; if (ir_in !== 32'h0) begin bad++; $display("FAIL reset_ir got=%h want=%h", ir_in, 32'h0); end
    total++;
    if ({bus.RAM_enable, ir_enable, ir_valid, busy, fetch_fault} !== 5'b0) begin
      bad++; $display("FAIL reset_strobes got=%b want=%b", {bus.RAM_enable, ir_enable, ir_valid, busy, fetch_fault}, 5'b0);
    end
    total++; if (bus.RAM_OpCode !== 6'b0) begin bad++; $display("FAIL reset_opcode got=%h want=%h", bus.RAM_OpCode, 6'b0); end
  endtask

  task automatic test_single_fetch();
    int first_v;
    int pulses;
    first_v   = 0;
    pulses    = 0;
    mfc_on    = 1'b1;
    mfc_delay = 2;
    fetch_req = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (n == 1) fetch_req = 1'b0;
      if (n == 2) begin
        total++; if (bus.RAM_enable !== 1'b1 || bus.RAM_Addr !== 9'h0) begin
          bad++; $display("FAIL single_wait_bus got=%b/%h want=1/000", bus.RAM_enable, bus.RAM_Addr);
        end
      end
      if (ir_valid) begin
        pulses++;
        if (first_v == 0) first_v = n;
        total++; if (ir_in !== 32'h8210_0001 || ir_enable !== 1'b1) begin
          bad++; $display("FAIL single_ir got=%h/%b want=82100001/1", ir_in, ir_enable);
        end
      end
    end
    total++; if (first_v !== 5) begin bad++; $display("FAIL single_latency got=%0d want=5", first_v); end
    total++; if (pulses !== 1) begin bad++; $display("FAIL single_pulses got=%0d want=1", pulses); end
    total++; if (pc_out !== 32'h4 || npc_out !== 32'h8) begin
      bad++; $display("FAIL single_pcnpc got=%h/%h want=4/8", pc_out, npc_out);
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [4];
    logic [8:0]  exp_a [4];
    int          vcyc [$];
    exp_w = '{32'h8210_0001, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
    exp_a = '{9'h000, 9'h004, 9'h008, 9'h00C};
    do_reset();
    mfc_delay = 0;
    fetch_req = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (ir_valid) begin
        vcyc.push_back(n);
        if (vcyc.size() <= 4) begin
          total++; if (ir_in !== exp_w[vcyc.size()-1]) begin
            bad++; $display("FAIL seq_word%0d got=%h want=%h", vcyc.size()-1, ir_in, exp_w[vcyc.size()-1]);
          end
        end
      end
    end
    fetch_req = 1'b0;
    tick();
    tick();
    total++; if (addr_log.size() !== 4) begin bad++; $display("FAIL seq_issue_count got=%0d want=4", addr_log.size()); end
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      total++; if (addr_log[i] !== exp_a[i]) begin bad++; $display("FAIL seq_addr%0d got=%h want=%h", i, addr_log[i], exp_a[i]); end
    end
    total++;
    if (vcyc.size() !== 4 || vcyc[0] !== 3 || vcyc[1] !== 6 || vcyc[2] !== 9 || vcyc[3] !== 12) begin
      bad++; $display("FAIL seq_valid_cycles got_count=%0d first=%0d want=3,6,9,12", vcyc.size(), (vcyc.size() > 0) ? vcyc[0] : -1);
    end
    total++; if (pc_out !== 32'h10 || npc_out !== 32'h14) begin
      bad++; $display("FAIL seq_pcnpc got=%h/%h want=10/14", pc_out, npc_out);
    end
    total++; if (ir_in !== 32'hA000_0003) begin bad++; $display("FAIL seq_ir_hold got=%h want=a0000003", ir_in); end
  endtask

  task automatic test_delayed_branch();
    logic [8:0] exp_a [5];
    bit         fired;
    bit         done;
    bit         ok;
    exp_a = '{9'h000, 9'h004, 9'h008, 9'h040, 9'h044};
    fired = 1'b0;
    done  = 1'b0;
    do_reset();
    mfc_delay = 1;
    fetch_req = 1'b1;
    for (int n = 0; n < 80; n++) begin
      tick();
      redirect = 1'b0;
      if (!fired && addr_log.size() == 2 && rcnt == 2) begin
        fired = 1'b1;
        total++; if (pc_out !== 32'h4 || npc_out !== 32'h8) begin
          bad++; $display("FAIL br_pre_pcnpc got=%h/%h want=4/8", pc_out, npc_out);
        end
        redirect        = 1'b1;
        redirect_target = 32'h0000_0040;
      end
      if (addr_log.size() >= 5) fetch_req = 1'b0;
      if (addr_log.size() >= 5 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    redirect  = 1'b0;
    fetch_req = 1'b0;
    total++; if (!done) begin bad++; $display("FAIL br_complete got=timeout want=idle"); end
    for (int i = 0; i < 5 && i < addr_log.size(); i++) begin
      total++; if (addr_log[i] !== exp_a[i]) begin bad++; $display("FAIL br_addr%0d got=%h want=%h", i, addr_log[i], exp_a[i]); end
    end
    total++; if (pc_out !== 32'h48 || npc_out !== 32'h4C) begin
      bad++; $display("FAIL br_post_pcnpc got=%h/%h want=48/4c", pc_out, npc_out);
    end

    // Misaligned target latched while idle, applied at the next DONE.
    redirect        = 1'b1;
    redirect_target = 32'h0000_0043;
    tick();
    redirect  = 1'b0;
    fetch_req = 1'b1;
    wait_valid(ok);
    fetch_req = 1'b0;
    tick();
    total++; if (!ok) begin bad++; $display("FAIL br_align_valid got=timeout want=pulse"); end
    total++; if (pc_out !== 32'h4C || npc_out !== 32'h40) begin
      bad++; $display("FAIL br_align_pcnpc got=%h/%h want=4c/40", pc_out, npc_out);
    end

    // Redirect raised during DONE itself takes effect immediately.
    fetch_req = 1'b1;
    wait_valid(ok);
    fetch_req       = 1'b0;
    redirect        = 1'b1;
    redirect_target = 32'h0000_0107;
    tick();
    redirect = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL br_live_valid got=timeout want=pulse"); end
    total++; if (pc_out !== 32'h40 || npc_out !== 32'h104) begin
      bad++; $display("FAIL br_live_pcnpc got=%h/%h want=40/104", pc_out, npc_out);
    end

    // No stale pending target: next DONE falls back to NPC+4.
    fetch_req = 1'b1;
    wait_valid(ok);
    fetch_req = 1'b0;
    tick();
    total++; if (pc_out !== 32'h104 || npc_out !== 32'h108) begin
      bad++; $display("FAIL br_no_stale got=%h/%h want=104/108", pc_out, npc_out);
    end
  endtask

  task automatic test_timeout();
    int fault_at;
    int valids;
    fault_at = 0;
    valids   = 0;
    do_reset();
    mfc_on    = 1'b0;
    fetch_req = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (n == 1) fetch_req = 1'b0;
      if (ir_valid) valids++;
      if (fetch_fault && fault_at == 0) fault_at = n;
      if (n == 16) begin
        total++; if (bus.RAM_enable !== 1'b1 || fetch_fault !== 1'b0) begin
          bad++; $display("FAIL to_last_wait got=%b/%b want=1/0", bus.RAM_enable, fetch_fault);
        end
      end
    end
`ifdef FETCH_TIMEOUT_EN
    total++; if (fault_at !== 17) begin bad++; $display("FAIL to_fault_cycle got=%0d want=17", fault_at); end
    total++; if (bus.RAM_enable !== 1'b0 || fetch_fault !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL to_fault_state got=%b/%b/%b want=0/1/1", bus.RAM_enable, fetch_fault, busy);
    end
`else
    total++; if (fault_at !== 0) begin bad++; $display("FAIL to_no_fault got=%0d want=0", fault_at); end
    total++; if (bus.RAM_enable !== 1'b1 || fetch_fault !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL to_wait_forever got=%b/%b/%b want=1/0/1", bus.RAM_enable, fetch_fault, busy);
    end
`endif
    total++; if (pc_out !== 32'h0 || npc_out !== 32'h4 || valids !== 0) begin
      bad++; $display("FAIL to_frozen got=%h/%h/%0d want=0/4/0", pc_out, npc_out, valids);
    end
    do_reset();
    mfc_on = 1'b1;
    total++; if (fetch_fault !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL to_reset_clear got=%b/%b want=0/0", fetch_fault, busy);
    end
  endtask

  task automatic test_reset_mid_fetch();
    int  valids;
    bit  ok;
    valids    = 0;
    do_reset();
    mfc_on    = 1'b1;
    mfc_delay = 5;
    redirect        = 1'b1;
    redirect_target = 32'h0000_0080;
    tick();
    redirect  = 1'b0;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    tick();
    total++; if (bus.RAM_enable !== 1'b1) begin bad++; $display("FAIL mid_in_wait got=%b want=1", bus.RAM_enable); end
    clr = 1'b0;
    tick();
    clr = 1'b1;
    total++; if (bus.RAM_enable !== 1'b0 || busy !== 1'b0 || pc_out !== 32'h0 || npc_out !== 32'h4) begin
      bad++; $display("FAIL mid_abort got=%b/%b/%h/%h want=0/0/0/4", bus.RAM_enable, busy, pc_out, npc_out);
    end
    for (int n = 0; n < 10; n++) begin
      tick();
      if (ir_valid) valids++;
    end
    total++; if (valids !== 0) begin bad++; $display("FAIL mid_no_valid got=%0d want=0", valids); end
    mfc_delay = 0;
    fetch_req = 1'b1;
    wait_valid(ok);
    fetch_req = 1'b0;
    tick();
    total++; if (!ok || pc_out !== 32'h4 || npc_out !== 32'h8) begin
      bad++; $display("FAIL mid_pending_cleared got=%b/%h/%h want=1/4/8", ok, pc_out, npc_out);
    end
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    rcnt            = 0;
    mfc_delay       = 0;
    mfc_on          = 1'b1;
    clr             = 1'b1;
    fetch_req       = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'h0;
    bus.MFC         = 1'b0;
    bus.RAM_Out     = 32'h0;
    for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[0] = 32'h8210_0001;

    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_delayed_branch();
    test_timeout();
    test_reset_mid_fetch();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
